rx_descrambler_32: RTL and testbench

Receive-side 32-bit descrambler for the PCIe Gen1/Gen2 (8b/10b) MAC path, and the counterpart of the transmit-side 32-bit scrambler LFSR. It processes four symbols per `pclk` using the polynomial x^16+x^5+x^4+x^3+1 with seed 16'hFFFF. It re-synchronises on COM, freezes on SKP and descrambles data symbols only. It sits between the receive symbol aligner/decoder and the ordered-set/packet parser.

---
 rtl/rx_descrambler_32.sv | 121 ++++++++++++
 tb/tb_rx_descrambler_32.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rx_descrambler_32.sv
// Receive-side 32-bit descrambler, four symbols per pclk, LFSR x^16+x^5+x^4+x^3+1.
// Re-seeds on COM, freezes on SKP and descrambles data symbols only once locked.
module rx_descrambler_32 (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        descramble_en,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_datak,
  input  logic        rx_valid,
  output logic [31:0] data_out,
  output logic [3:0]  datak_out,
  output logic        data_valid,
  output logic        locked
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hFFFF;
  localparam logic [7:0]  SYM_COM   = 8'hBC;
  localparam logic [7:0]  SYM_SKP   = 8'h1C;

  lock_state_t state_r;
  lock_state_t state_nxt_s;
  logic [15:0] lfsr_r;
  logic [15:0] lfsr_nxt_s;
  logic [15:0] q_s;
  logic        lock_s;
  logic [23:0] step_s;
  logic [7:0]  byte_s;
  logic [31:0] desc_s;

  // Eight serial LFSR steps: returns {keystream byte, advanced state}; bit i is q[15] before step i.
  function automatic logic [23:0] lfsr_byte(input logic [15:0] q_in);
    logic [15:0] q;
    logic [7:0]  k;
    q = q_in;
    k = 8'h00;
    for (int i = 0; i < 8; i++) begin
      k[i] = q[15];
      q    = {q[14:0], 1'b0} ^ (q[15] ? 16'h0039 : 16'h0000);
    end
    return {k, q};
  endfunction

  // Per-byte descramble with the LFSR state and lock status chained across the four symbols.
  always_comb begin
    q_s    = lfsr_r;
    desc_s = rx_data;
    step_s = 24'h000000;
    byte_s = 8'h00;
    case (state_r)
      ST_LOCKED: lock_s = 1'b1;
      default:   lock_s = 1'b0;
    endcase
    for (int b = 0; b < 4; b++) begin
      byte_s = rx_data[8*b +: 8];
      step_s = lfsr_byte(q_s);
      if (rx_datak[b] && (byte_s == SYM_COM)) begin
        q_s    = LFSR_SEED;
        lock_s = 1'b1;
      end else if (rx_datak[b] && (byte_s == SYM_SKP)) begin
        q_s = q_s;
      end else if (rx_datak[b]) begin
        q_s = step_s[15:0];
      end else if (lock_s) begin
        desc_s[8*b +: 8] = byte_s ^ step_s[23:16];
        q_s              = step_s[15:0];
      end else begin
        q_s = q_s;
      end
    end
  end

  // Next LFSR/lock state: bypass forces the seed and unlock; idle cycles hold.
  always_comb begin
    lfsr_nxt_s  = lfsr_r;
    state_nxt_s = state_r;
    if (!descramble_en) begin
      lfsr_nxt_s  = LFSR_SEED;
      state_nxt_s = ST_UNLOCKED;
    end else if (rx_valid) begin
      lfsr_nxt_s  = q_s;
      state_nxt_s = lock_s ? ST_LOCKED : ST_UNLOCKED;
    end else begin
      lfsr_nxt_s  = lfsr_r;
      state_nxt_s = state_r;
    end
  end

  // State registers.
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      lfsr_r  <= LFSR_SEED;
      state_r <= ST_UNLOCKED;
      locked  <= 1'b0;
    end else begin
      lfsr_r  <= lfsr_nxt_s;
      state_r <= state_nxt_s;
      locked  <= (state_nxt_s == ST_LOCKED);
    end
  end

  // Registered output word; data and K flags hold across invalid cycles.
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      data_out   <= 32'h00000000;
      datak_out  <= 4'b0000;
      data_valid <= 1'b0;
    end else if (rx_valid) begin
      data_out   <= descramble_en ? desc_s : rx_data;
      datak_out  <= rx_datak;
      data_valid <= 1'b1;
    end else begin
      data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_descrambler_32.sv
// Directed self-checking bench for rx_descrambler_32 with hand-computed keystream
// (seed FFFF gives FF,17,C0,14,B2,E7,02,82).
module tb_rx_descrambler_32;

  logic        pclk;
  logic        reset_n;
  logic        descramble_en;
  logic [31:0] rx_data;
  logic [3:0]  rx_datak;
  logic        rx_valid;
  logic [31:0] data_out;
  logic [3:0]  datak_out;
  logic        data_valid;
  logic        locked;

  int n_checks;
  int n_pass;

  rx_descrambler_32 dut (
    .pclk          (pclk),
    .reset_n       (reset_n),
    .descramble_en (descramble_en),
    .rx_data       (rx_data),
    .rx_datak      (rx_datak),
    .rx_valid      (rx_valid),
    .data_out      (data_out),
    .datak_out     (datak_out),
    .data_valid    (data_valid),
    .locked        (locked)
  );

  // Free-running 10 ns clock.
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] d, input logic [3:0] k, input logic v, input logic en);
    @(negedge pclk);
    rx_data       = d;
    rx_datak      = k;
    rx_valid      = v;
    descramble_en = en;
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    reset_n  = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 32'hDEADBEEF;
    rx_datak = 4'b0000;
    repeat (2) @(posedge pclk);
    #1;
    @(negedge pclk);
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset_n       = 1'b0;
    descramble_en = 1'b1;
    rx_data       = 32'h00000000;
    rx_datak      = 4'b0000;
    rx_valid      = 1'b0;

    do_reset();
    check("rst_data",   data_out, 32'h00000000);
    check("rst_datak",  {28'h0, datak_out}, 32'h00000000);
    check("rst_valid",  {31'h0, data_valid}, 32'h00000000);
    check("rst_locked", {31'h0, locked}, 32'h00000000);

    // Unlocked data passes raw, then COM mid-word keys the bytes after it
    cyc(32'h12345678, 4'b0000, 1'b1, 1'b1);
    check("unlk_data",   data_out, 32'h12345678);
    check("unlk_locked", {31'h0, locked}, 32'h00000000);
    check("unlk_valid",  {31'h0, data_valid}, 32'h00000001);
    cyc(32'h0000BC00, 4'b0010, 1'b1, 1'b1);
    check("midcom_data",   data_out, 32'h17FFBC00);
    check("midcom_locked", {31'h0, locked}, 32'h00000001);

    // Fresh reset, COM in byte 0 then zero data
    do_reset();
    cyc(32'h000000BC, 4'b0001, 1'b1, 1'b1);
    check("com_data",   data_out, 32'hC017FFBC);
    check("com_datak",  {28'h0, datak_out}, 32'h00000001);
    check("com_locked", {31'h0, locked}, 32'h00000001);
    cyc(32'h00000000, 4'b0000, 1'b1, 1'b1);
    check("ks_word1", data_out, 32'h02E7B214);
    cyc(32'h00000000, 4'b0000, 1'b1, 1'b1);
    check("ks_byte8", {24'h0, data_out[7:0]}, 32'h00000082);

    // COM followed by SKPs: SKP must not advance the LFSR
    cyc(32'h1C1C1CBC, 4'b1111, 1'b1, 1'b1);
    check("skp_data",  data_out, 32'h1C1C1CBC);
    check("skp_datak", {28'h0, datak_out}, 32'h0000000F);
    cyc(32'h00000000, 4'b0000, 1'b1, 1'b1);
    check("skp_after", data_out, 32'h14C017FF);

    // Three idle cycles, then keystream resumes at B2
    for (int i = 0; i < 3; i++) begin
      cyc(32'hFFFFFFFF, 4'b1111, 1'b0, 1'b1);
      check("gap_valid", {31'h0, data_valid}, 32'h00000000);
      check("gap_hold",  data_out, 32'h14C017FF);
    end
    cyc(32'h00000000, 4'b0000, 1'b1, 1'b1);
    check("gap_resume", data_out, 32'h8202E7B2);

    // One-cycle disable: bypass and unlock, stay raw until the next COM
    cyc(32'hAABBCCDD, 4'b0000, 1'b1, 1'b0);
    check("dis_data",   data_out, 32'hAABBCCDD);
    check("dis_locked", {31'h0, locked}, 32'h00000000);
    cyc(32'h11223344, 4'b0000, 1'b1, 1'b1);
    check("reen_data",   data_out, 32'h11223344);
    check("reen_locked", {31'h0, locked}, 32'h00000000);
    cyc(32'h000000BC, 4'b0001, 1'b1, 1'b1);
    check("relock_data",   data_out, 32'hC017FFBC);
    check("relock_locked", {31'h0, locked}, 32'h00000001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
